// File: rtl/cpu_types_pkg.sv
// Shared CPU cache types: icache FSM state and the one-word frame record.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cpu_types_pkg;

    // Widest tag any legal icache geometry can need: NFRAMES >= 2 gives
    // at least one index bit, leaving at most 32 - 2 - 1 = 29 tag bits.
    localparam int ICACHE_TAG_MAXW = 29;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    // Tags narrower than ICACHE_TAG_MAXW are stored zero-extended; the
    // constant upper bits disappear in synthesis.
    typedef struct packed {
        logic                       valid;
        logic [ICACHE_TAG_MAXW-1:0] tag;
        logic [31:0]                data;
    } icache_frame_t;

    // Saturating increment for 32-bit event counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a blocking single-miss fill.
// Latency: hit is combinational in the request cycle; miss costs (iwait-high cycles + 1) in FILL, then hits.
// Backpressure: memory stalls via iwait; the datapath is stalled by holding ihit low until the word is present.
//
// Ports:
//   CLK, nRST                 clock, asynchronous active-low reset
//   imemREN, imemaddr         datapath instruction fetch request / byte address
//   ihit, imemload            fetch complete this cycle / instruction word
//   iREN, iaddr               memory-side read request / address
//   iwait, iload              memory busy / memory read data
//   hit_count, miss_count     (only with ICACHE_STATS_EN defined) saturating event counters
module icache
    import cpu_types_pkg::*;
#(
    parameter int NFRAMES = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDXW = $clog2(NFRAMES);
    localparam int TAGW = 30 - IDXW;

    // Storage: valid bits carry the reset, tag/data do not need one.
    logic [NFRAMES-1:0]          valid_q;
    logic [ICACHE_TAG_MAXW-1:0]  tag_q  [NFRAMES];
    logic [31:0]                 data_q [NFRAMES];

    icache_state_t state_q, state_d;
    logic [31:0]   miss_addr_q, miss_addr_d;

    logic [IDXW-1:0] lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic [IDXW-1:0] miss_idx;
    logic [TAGW-1:0] miss_tag;
    icache_frame_t   lookup;
    logic            lookup_hit;
    logic            fill_we;
    logic            start_fill;

    assign lk_idx   = imemaddr[IDXW+1:2];
    assign lk_tag   = imemaddr[31:IDXW+2];
    assign miss_idx = miss_addr_q[IDXW+1:2];
    assign miss_tag = miss_addr_q[31:IDXW+2];

    // The frame selected by the live request address; imemload always
    // shows its data, so a hit needs no extra mux.
    always_comb begin
        lookup.valid = valid_q[lk_idx];
        lookup.tag   = tag_q[lk_idx];
        lookup.data  = data_q[lk_idx];
    end

    assign lookup_hit = lookup.valid && (lookup.tag == ICACHE_TAG_MAXW'(lk_tag));
    assign imemload   = lookup.data;

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        ihit        = 1'b0;
        iREN        = 1'b0;
        iaddr       = imemaddr;
        fill_we     = 1'b0;
        start_fill  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (imemREN) begin
                    if (lookup_hit) begin
                        ihit = 1'b1;
                    end else begin
                        miss_addr_d = imemaddr;
                        start_fill  = 1'b1;
                        state_d     = FILL;
                    end
                end
            end
            FILL: begin
                // Fill runs to completion against the latched address even
                // if the datapath redirects; the new address is looked up
                // once back in IDLE.
                iREN  = 1'b1;
                iaddr = miss_addr_q;
                if (!iwait) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            if (fill_we) begin
                valid_q[miss_idx] <= 1'b1;
            end
        end
    end

    // fill_we depends on state_q, which reset forces to IDLE, so a fill
    // interrupted by reset never reaches the arrays.
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            tag_q[miss_idx]  <= ICACHE_TAG_MAXW'(miss_tag);
            data_q[miss_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (ihit) begin
            hit_count_d = sat_inc32(hit_count_q);
        end
        if (start_fill) begin
            miss_count_d = sat_inc32(miss_count_q);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    // start_fill only feeds the miss counter.
    logic unused_start_fill;
    assign unused_start_fill = start_fill;
`endif

endmodule
